// File: rtl/alsu_cmd_issuer_if.sv
// Command/response interface between a host sequencer and alsu_cmd_issuer.
// The master (host) offers packed commands and accepts responses.
// The slave (issuer) accepts commands and returns captured ALSU results.
interface alsu_cmd_issuer_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [15:0] cmd_data;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [5:0]  rsp_data;
    logic        rsp_err;

    modport master (
        output cmd_valid,
        output cmd_data,
        input  cmd_ready,
        input  rsp_valid,
        input  rsp_data,
        input  rsp_err,
        output rsp_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_data,
        output cmd_ready,
        output rsp_valid,
        output rsp_data,
        output rsp_err,
        input  rsp_ready
    );
endinterface

// File: rtl/alsu_cmd_issuer.sv
// alsu_cmd_issuer: drives one packed command at a time onto the ALSU pins,
// waits out the ALSU register latency, captures alsu_out and returns it on
// the response port. One command in flight; no overlap.
// cmd_data = {opcode[15:13], A[12:10], B[9:7], cin, si, red_op_A, red_op_B,
//             bypass_A, bypass_b, direction}
// Optional feature macro: ISSUER_ERRCHK_EN enables the illegal-command
// checker that drives rsp_err; without it rsp_err is tied to 0.
module alsu_cmd_issuer #(
    parameter int ALSU_LATENCY = 2,
    parameter int CNT_W        = 8
) (
    input  logic             clk,
    input  logic             rst,
    alsu_cmd_issuer_if.slave cmd_if,
    output logic [2:0]       alsu_opcode,
    output logic [2:0]       alsu_A,
    output logic [2:0]       alsu_B,
    output logic [6:0]       alsu_ctrl,
    input  logic [5:0]       alsu_out,
    output logic [CNT_W-1:0] issued_cnt
);

    localparam int LAT_W = (ALSU_LATENCY < 1) ? 1 : $clog2(ALSU_LATENCY + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [LAT_W-1:0] lat_cnt;
    logic             accept;
    logic             capture;
    logic             complete;
    logic             err_d;

    // Next-state and handshake decode; cmd_ready/rsp_valid are pure state decodes
    // so they can never be high together.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned
        // (which would infer a latch).
        state_d          = state_q;
        accept           = 1'b0;
        capture          = 1'b0;
        complete         = 1'b0;
        cmd_if.cmd_ready = 1'b0;
        cmd_if.rsp_valid = 1'b0;
        case (state_q)
            IDLE: begin
                cmd_if.cmd_ready = 1'b1;
                if (cmd_if.cmd_valid) begin
                    accept  = 1'b1;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (lat_cnt == '0) begin
                    capture = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                cmd_if.rsp_valid = 1'b1;
                if (cmd_if.rsp_ready) begin
                    complete = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Illegal-command decision, taken from the held drive registers at capture.
`ifdef ISSUER_ERRCHK_EN
    always_comb begin
        err_d = 1'b0;
        if (!(alsu_ctrl[2] || alsu_ctrl[1])) begin
            if (alsu_opcode >= 3'd6)
                err_d = 1'b1;
            else if ((alsu_opcode >= 3'd2) && (alsu_ctrl[4] || alsu_ctrl[3]))
                err_d = 1'b1;
        end
    end
`else
    assign err_d = 1'b0;
`endif

    // FSM state register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Latency countdown: loaded on accept, counts down while waiting.
    always_ff @(posedge clk) begin
        if (rst)
            lat_cnt <= '0;
        else if (accept)
            lat_cnt <= LAT_W'(ALSU_LATENCY);
        else if (state_q == WAIT && lat_cnt != '0)
            lat_cnt <= lat_cnt - LAT_W'(1);
    end

    // ALSU drive registers: hold the last accepted command until the next accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            alsu_opcode <= '0;
            alsu_A      <= '0;
            alsu_B      <= '0;
            alsu_ctrl   <= '0;
        end else if (accept) begin
            alsu_opcode <= cmd_if.cmd_data[15:13];
            alsu_A      <= cmd_if.cmd_data[12:10];
            alsu_B      <= cmd_if.cmd_data[9:7];
            alsu_ctrl   <= cmd_if.cmd_data[6:0];
        end
    end

    // Response capture: result and error flag frozen at the capture edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_if.rsp_data <= '0;
            cmd_if.rsp_err  <= 1'b0;
        end else if (capture) begin
            cmd_if.rsp_data <= alsu_out;
            cmd_if.rsp_err  <= err_d;
        end
    end

    // Completed-command counter; wraps silently.
    always_ff @(posedge clk) begin
        if (rst)
            issued_cnt <= '0;
        else if (complete)
            issued_cnt <= issued_cnt + CNT_W'(1);
    end

endmodule

// File: tb/tb_alsu_cmd_issuer.sv
// Self-checking bench for alsu_cmd_issuer: a behavioural ALSU stand-in with two
// register stages, a directed vector table, hand-written stall/reset sequences
// and a randomized run checked against a scoreboard of expected responses.
module tb_alsu_cmd_issuer;

    logic       clk;
    logic       rst;
    logic [2:0] alsu_opcode;
    logic [2:0] alsu_A;
    logic [2:0] alsu_B;
    logic [6:0] alsu_ctrl;
    logic [5:0] alsu_out;
    logic [7:0] issued_cnt;

    alsu_cmd_issuer_if bus ();

    alsu_cmd_issuer #(.ALSU_LATENCY(2), .CNT_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_if     (bus),
        .alsu_opcode(alsu_opcode),
        .alsu_A     (alsu_A),
        .alsu_B     (alsu_B),
        .alsu_ctrl  (alsu_ctrl),
        .alsu_out   (alsu_out),
        .issued_cnt (issued_cnt)
    );

`ifdef ISSUER_ERRCHK_EN
    localparam logic ERRCHK = 1'b1;
`else
    localparam logic ERRCHK = 1'b0;
`endif

    localparam logic [6:0] C_CIN  = 7'b1000000;
    localparam logic [6:0] C_REDA = 7'b0010000;
    localparam logic [6:0] C_REDB = 7'b0001000;
    localparam logic [6:0] C_BYPA = 7'b0000100;
    localparam logic [6:0] C_BYPB = 7'b0000010;

    int checks   = 0;
    int failures = 0;
    int both_bad = 0;
    int exp_cnt  = 0;

    logic [5:0] exp_q[$];
    logic       err_q[$];
    logic       chk_q[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] mk(input logic [2:0] op, input logic [2:0] a,
                                       input logic [2:0] b, input logic [6:0] ctrl);
        return {op, a, b, ctrl};
    endfunction

    // ALSU result for a held command (non-shift opcodes, or any bypassed command).
    function automatic logic [5:0] ref_result(input logic [15:0] c);
        logic [2:0] op, a, b;
        logic       cin, ra, rb, ba, bb;
        op  = c[15:13]; a = c[12:10]; b = c[9:7];
        cin = c[6]; ra = c[4]; rb = c[3]; ba = c[2]; bb = c[1];
        if (ba) return {3'b000, a};
        if (bb) return {3'b000, b};
        case (op)
            3'd0: begin
                if (ra)      return {5'b0, &a};
                else if (rb) return {5'b0, &b};
                else         return {3'b0, a & b};
            end
            3'd1: begin
                if (ra)      return {5'b0, ^a};
                else if (rb) return {5'b0, ^b};
                else         return {3'b0, a ^ b};
            end
            3'd2:    return (ra || rb) ? 6'd0 : 6'(a) + 6'(b) + 6'(cin);
            3'd3:    return (ra || rb) ? 6'd0 : 6'(a) * 6'(b);
            default: return 6'd0;
        endcase
    endfunction

    // Illegal-command rule in the checker-enabled build.
    function automatic logic ref_err(input logic [15:0] c);
        int  op;
        logic red, byp;
        op  = int'(c[15:13]);
        red = c[4] | c[3];
        byp = c[2] | c[1];
        if (!ERRCHK || byp) return 1'b0;
        return (op >= 6) || (op >= 2 && op <= 5 && red);
    endfunction

    // Shift/rotate results depend on ALSU history; only bypassed ones are predictable.
    function automatic logic predictable(input logic [15:0] c);
        return c[2] || c[1] || !(c[15:13] == 3'd4 || c[15:13] == 3'd5);
    endfunction

    // Behavioural ALSU: input register stage, then output register stage.
    logic [15:0] s_cmd;
    always @(posedge clk) begin
        if (rst) begin
            s_cmd    <= '0;
            alsu_out <= '0;
        end else begin
            s_cmd <= {alsu_opcode, alsu_A, alsu_B, alsu_ctrl};
            if (!predictable(s_cmd) && !(s_cmd[4] || s_cmd[3])) begin
                if (s_cmd[15:13] == 3'd4)
                    alsu_out <= s_cmd[0] ? {alsu_out[4:0], s_cmd[5]} : {s_cmd[5], alsu_out[5:1]};
                else
                    alsu_out <= s_cmd[0] ? {alsu_out[4:0], alsu_out[5]} : {alsu_out[0], alsu_out[5:1]};
            end else begin
                alsu_out <= ref_result(s_cmd);
            end
        end
    end

    // Mutual exclusion monitor for the two handshake outputs.
    always @(negedge clk) begin
        if (!rst && bus.cmd_ready === 1'b1 && bus.rsp_valid === 1'b1) both_bad++;
    end

    // Offer a command and return #1 after the accept edge.
    task automatic send(input logic [15:0] c);
        int guard;
        @(negedge clk);
        bus.cmd_data  = c;
        bus.cmd_valid = 1'b1;
        guard = 0;
        while (bus.cmd_ready !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("cmd_accept", 32'(guard < 50), 32'd1);
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
    endtask

    // Count edges from accept until rsp_valid; flags any cmd_ready while busy.
    task automatic wait_rsp(output int lat, output int busy_ready);
        lat = 0;
        busy_ready = 0;
        while (bus.rsp_valid !== 1'b1 && lat < 20) begin
            if (bus.cmd_ready !== 1'b0) busy_ready++;
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic finish_rsp();
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b0;
        exp_cnt++;
    endtask

    // One full transaction with a stall of 'hold' cycles before rsp_ready.
    task automatic run_txn(input string name, input logic [15:0] c, input logic [5:0] exp_d,
                           input logic do_data, input logic exp_e, input int hold);
        int lat, busy, unstable;
        logic [5:0] snap;
        send(c);
        wait_rsp(lat, busy);
        check({name, "_latency"}, 32'(lat), 32'd3);
        check({name, "_busy_ready"}, 32'(busy), 32'd0);
        snap = bus.rsp_data;
        unstable = 0;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== snap || bus.cmd_ready !== 1'b0)
                unstable++;
        end
        check({name, "_hold"}, 32'(unstable), 32'd0);
        if (do_data) check({name, "_data"}, 32'(bus.rsp_data), 32'(exp_d));
        check({name, "_err"}, 32'(bus.rsp_err), 32'(exp_e));
        finish_rsp();
        check({name, "_cnt"}, 32'(issued_cnt), 32'(exp_cnt[7:0]));
        check({name, "_idle"}, 32'({bus.cmd_ready, bus.rsp_valid}), 32'b10);
        check({name, "_drive_hold"}, 32'({alsu_opcode, alsu_A, alsu_B, alsu_ctrl}), 32'(c));
    endtask

    typedef struct {
        string       name;
        logic [15:0] cmd;
        logic [5:0]  exp_data;
        logic        exp_err;
    } vec_t;

    vec_t vecs[9];

    initial begin
        int quiet;
        logic [15:0] c;

        vecs[0] = '{"add",      mk(3'd2, 3'd3, 3'd2, C_CIN),           6'd6,  1'b0};
        vecs[1] = '{"bypa",     mk(3'd0, 3'd4, 3'd0, C_BYPA),          6'd4,  1'b0};
        vecs[2] = '{"bypab",    mk(3'd0, 3'd1, 3'd5, C_BYPA | C_BYPB), 6'd1,  1'b0};
        vecs[3] = '{"op6",      mk(3'd6, 3'd3, 3'd3, 7'd0),            6'd0,  ERRCHK};
        vecs[4] = '{"add_reda", mk(3'd2, 3'd3, 3'd2, C_REDA),          6'd0,  ERRCHK};
        vecs[5] = '{"and",      mk(3'd0, 3'd5, 3'd3, 7'd0),            6'd1,  1'b0};
        vecs[6] = '{"xor_redb", mk(3'd1, 3'd0, 3'd7, C_REDB),          6'd1,  1'b0};
        vecs[7] = '{"mul_bypb", mk(3'd3, 3'd2, 3'd6, C_REDA | C_BYPB), 6'd6,  1'b0};
        vecs[8] = '{"op7_bypa", mk(3'd7, 3'd2, 3'd5, C_BYPA),          6'd2,  1'b0};

        rst = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_data  = '0;
        bus.rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state.
        check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_rsp_data",  32'(bus.rsp_data),  32'd0);
        check("rst_rsp_err",   32'(bus.rsp_err),   32'd0);
        check("rst_issued",    32'(issued_cnt),    32'd0);
        check("rst_drive",     32'({alsu_opcode, alsu_A, alsu_B, alsu_ctrl}), 32'd0);

        // Directed vector table.
        for (int i = 0; i < 9; i++)
            run_txn(vecs[i].name, vecs[i].cmd, vecs[i].exp_data, 1'b1, vecs[i].exp_err, 0);

        // MUL with the response consumer stalled for 5 cycles.
        run_txn("mul_stall", mk(3'd3, 3'd7, 3'd7, 7'd0), 6'd49, 1'b1, 1'b0, 5);

        // Reset pulse while waiting on the ALSU: the command vanishes.
        send(mk(3'd0, 3'd7, 3'd7, 7'd0));
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_cnt = 0;
        check("midrst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        check("midrst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("midrst_issued",    32'(issued_cnt),    32'd0);
        check("midrst_drive",     32'({alsu_opcode, alsu_A, alsu_B, alsu_ctrl}), 32'd0);
        quiet = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            if (bus.rsp_valid !== 1'b0) quiet++;
        end
        check("midrst_no_rsp", 32'(quiet), 32'd0);
        run_txn("post_rst_and", mk(3'd0, 3'd5, 3'd3, 7'd0), 6'd1, 1'b1, 1'b0, 0);

        // Randomized commands against the scoreboard; long enough to wrap issued_cnt.
        for (int n = 0; n < 270; n++) begin
            c = 16'($urandom);
            exp_q.push_back(ref_result(c));
            err_q.push_back(ref_err(c));
            chk_q.push_back(predictable(c));
            run_txn($sformatf("rnd%0d", n), c, exp_q.pop_front(), chk_q.pop_front(),
                    err_q.pop_front(), int'($urandom_range(0, 3)));
        end

        check("never_both_ready_valid", 32'(both_bad), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time bound so a stuck design still terminates.
    initial begin
        #500000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
